// File: rtl/pipeline_stall_controller_pkg.sv
// Shared encodings and defaults for the pipeline freeze/flush sequencer.
package pipeline_stall_controller_pkg;

  localparam int unsigned FLUSH_CYCLES_DEF = 1;
  localparam int unsigned CNT_WIDTH_DEF    = 16;
  localparam int unsigned FCNT_W           = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_exe_flush;
    logic back_freeze;
  } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/flush sequencer: merges hazard, branch and memory-wait into per-stage control.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_freeze,
  output logic                 if_id_freeze,
  output logic                 if_id_flush,
  output logic                 id_exe_flush,
  output logic                 back_freeze,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [1:0]           state_dbg
);

  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam bit                MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  ctrl_t             ctrl_d, ctrl_o;
  logic              mem_stall;

  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state and Mealy control; RUN and the MEM_WAIT release share the same rules.
  always_comb begin
    ctrl_d  = '0;
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          ctrl_d.pc_freeze    = 1'b1;
          ctrl_d.if_id_freeze = 1'b1;
          ctrl_d.back_freeze  = 1'b1;
          state_d             = ST_MEM_WAIT;
        end else if (branch_taken) begin
          ctrl_d.if_id_flush  = 1'b1;
          ctrl_d.id_exe_flush = 1'b1;
          if (MULTI_FLUSH) begin
            fcnt_d  = FLUSH_RELOAD;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
          if (hazard_detected) begin
            ctrl_d.pc_freeze    = 1'b1;
            ctrl_d.if_id_freeze = 1'b1;
            ctrl_d.id_exe_flush = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (mem_stall) begin
          ctrl_d.pc_freeze    = 1'b1;
          ctrl_d.if_id_freeze = 1'b1;
          ctrl_d.back_freeze  = 1'b1;
        end else if (branch_taken) begin
          ctrl_d.if_id_flush  = 1'b1;
          ctrl_d.id_exe_flush = 1'b1;
          fcnt_d              = FLUSH_RELOAD;
          state_d             = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
        end else begin
          ctrl_d.if_id_flush = 1'b1;
          fcnt_d             = fcnt_q - FCNT_W'(1);
          if (fcnt_q == FCNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  assign ctrl_o       = rst ? ctrl_d : '0;
  assign pc_freeze    = ctrl_o.pc_freeze;
  assign if_id_freeze = ctrl_o.if_id_freeze;
  assign if_id_flush  = ctrl_o.if_id_flush;
  assign id_exe_flush = ctrl_o.id_exe_flush;
  assign back_freeze  = ctrl_o.back_freeze;
  assign state_dbg    = state_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl_o.pc_freeze),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl_o.if_id_flush),
    .count (flush_count)
  );

endmodule
